// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter.
// Register writes push bytes into a small FIFO. A four-state FSM moves each
// byte onto txd. Register reads are combinational so the bus bridge can mux
// them directly. The bit divisor is re-sampled at every bit boundary, so a
// divisor change only ever takes effect from the start of the next bit.
module uart_tx_dev #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH   = 5'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_DIV    = 2'd3
  } reg_sel_t;

  // Register decode. Only the low two word-address bits select a register,
  // so every store hits exactly one of the four registers.
  reg_sel_t sel;
  logic     wr_data;
  logic     wr_status;
  logic     wr_ctrl;
  logic     wr_div;

  assign sel       = reg_sel_t'(Addr[1:0]);
  assign wr_data   = WE && (sel == REG_DATA);
  assign wr_status = WE && (sel == REG_STATUS);
  assign wr_ctrl   = WE && (sel == REG_CTRL);
  assign wr_div    = WE && (sel == REG_DIV);

  // The upper address bits and the upper data half are not used by any
  // register. This reduction only marks them as intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  // Control and configuration registers.
  logic        tx_en;
  logic        irq_en;
  logic [15:0] div_reg;
  logic        overflow;

  // FIFO state.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             full;
  logic             empty;
  logic             push;
  logic             drop;

  // Transmit FSM and bit timer.
  state_t      state;
  state_t      next_state;
  logic        pop;
  logic [15:0] bit_cnt;
  logic [15:0] cur_div;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        bit_done;
  logic        busy;

  assign full  = (count == DEPTH);
  assign empty = (count == 5'd0);

  // A pop in the same cycle frees the slot that this push reuses. With full
  // FIFO pointers, wr_ptr equals rd_ptr, so the head is read out and replaced
  // on the same edge.
  assign push = wr_data && (!full || pop);
  assign drop = wr_data && full && !pop;

  // Register file: CTRL, DIV and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      div_reg  <= DIV_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en  <= Din[0];
        irq_en <= Din[1];
      end
      if (wr_div) begin
        div_reg <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
      end
      if (wr_status) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy count. Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: written on an accepted push only.
  // NOTE: the data array has no reset. Entries are only read after a push has written them, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Din[7:0];
    end
  end

  // The bit timer runs from 0 to cur_div-1. cur_div is a snapshot of DIV taken at each bit boundary.
  assign bit_done = (bit_cnt == (cur_div - 16'd1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and line level. A frame can be followed immediately by the next one straight from the stop bit.
  // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    txd        = 1'b1;
    case (state)
      S_IDLE: begin
        txd = 1'b1;
        if (tx_en && !empty) begin
          pop        = 1'b1;
          next_state = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (bit_done) begin
          next_state = S_DATA;
        end
      end
      S_DATA: begin
        txd = shift[0];
        if (bit_done && (bit_idx == 3'd7)) begin
          next_state = S_STOP;
        end
      end
      S_STOP: begin
        txd = 1'b1;
        if (bit_done) begin
          if (tx_en && !empty) begin
            pop        = 1'b1;
            next_state = S_START;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Bit timer, divisor snapshot and shift register. A pop loads a fresh frame.
  // Otherwise the timer advances while a frame is on the line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= 16'd0;
      cur_div <= DIV_RST;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
    end else if (pop) begin
      bit_cnt <= 16'd0;
      cur_div <= div_reg;
      shift   <= mem[rd_ptr];
      bit_idx <= 3'd0;
    end else if (state != S_IDLE) begin
      if (bit_done) begin
        bit_cnt <= 16'd0;
        cur_div <= div_reg;
        if (state == S_DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        bit_cnt <= bit_cnt + 16'd1;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign IRQ  = irq_en && empty && (state == S_IDLE);

  // Combinational read mux for the bridge. Unassigned bits read as zero.
  always_comb begin
    Dout = 32'd0;
    case (sel)
      REG_DATA:   Dout = 32'd0;
      REG_STATUS: Dout[8:0] = {count, overflow, empty, full, busy};
      REG_CTRL:   Dout[1:0] = {irq_en, tx_en};
      REG_DIV:    Dout[15:0] = div_reg;
      default:    Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench for uart_tx_dev.
// The stimulus pushes an expected frame description into a queue for each
// accepted byte: data, per-bit durations, whether the frame must follow the
// previous one with no gap, and whether a reset is meant to cut it short.
// A separate monitor watches txd and checks every frame it sees against the
// head of that queue.
module tb_uart_tx_dev;

  localparam int DEPTH = 4;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  uart_tx_dev #(.CLK_DIV(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .txd  (txd)
  );

  typedef struct {
    logic [7:0] data;
    int         dur [10];
    bit         chained;
    bit         abort;
  } frame_t;

  frame_t exp_q[$];
  int     total;
  int     bad;
  int     cyc;
  int     frames;
  bit     mon_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter, used to check frame-to-frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input int div, input bit chained);
    frame_t f;
    f.data = d;
    for (int k = 0; k < 10; k++) f.dur[k] = div;
    f.chained = chained;
    f.abort   = 1'b0;
    return f;
  endfunction

  function automatic logic [31:0] status_word(input int busy, input int cnt, input int ovf);
    return 32'((cnt << 4) | (ovf << 3) | ((cnt == 0) ? 4 : 0) | ((cnt == DEPTH) ? 2 : 0) | busy);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'($urandom), a};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #2;
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'($urandom), a};
    #1;
    d = Dout;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  // Wait until every expected frame has gone by and the transmitter is idle.
  task automatic drain(input string name);
    logic [31:0] s;
    int i;
    for (i = 0; i < 3000; i++) begin
      rd(A_STATUS, s);
      if (exp_q.size() == 0 && !mon_busy && s[0] == 1'b0) break;
      step();
    end
    check({name, "_drain_in_budget"}, 32'(i < 3000), 32'd1);
  endtask

  // Monitor: detects start bits on txd and checks each bit window of the frame
  // sample by sample. Frames flagged as chained must start on the very next
  // cycle after the previous stop bit.
  initial begin : monitor
    frame_t f;
    int     start_cyc;
    int     last_end;
    int     good;
    bit     aborted;
    logic   lv;
    last_end = -100;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        mon_busy  = 1'b1;
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("frame_was_expected", 32'(exp_q.size()), 32'd1);
          while (txd !== 1'b1) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          frames++;
          if (f.chained) check($sformatf("frame%0d_no_gap", frames), 32'(start_cyc), 32'(last_end + 1));
          aborted = 1'b0;
          for (int k = 0; k < 10 && !aborted; k++) begin
            lv   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.data[k-1];
            good = 0;
            for (int d = 0; d < f.dur[k]; d++) begin
              if (!(k == 0 && d == 0)) @(negedge clk);
              if (reset !== 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (txd === lv) good++;
            end
            if (!aborted) check($sformatf("frame%0d_bit%0d", frames, k), 32'(good), 32'(f.dur[k]));
          end
          check($sformatf("frame%0d_abort", frames), 32'(aborted), 32'(f.abort));
          last_end = cyc;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          n;
    int          cnt;
    int          ovf;
    int          div;
    int          dw;
    int          irq_bit;
    int          busy_cycles;
    int          delay;
    bit          seen;
    logic [7:0]  b;
    logic [31:0] v;
    frame_t      f;

    total  = 0;
    bad    = 0;
    cyc    = 0;
    frames = 0;
    reset  = 1'b0;
    WE     = 1'b0;
    Addr   = 30'd0;
    Din    = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);
    check_reg("rst_status", A_STATUS, 32'h4);
    check_reg("rst_div", A_DIV, 32'd16);
    check_reg("rst_ctrl", A_CTRL, 32'd0);
    check_reg("rst_data_reads_0", A_DATA, 32'd0);

    // A divisor of 0 is stored as 1. Then run a single 0xA5 frame at DIV=4.
    wr(A_DIV, 32'd0);
    check_reg("div_zero_as_one", A_DIV, 32'd1);
    wr(A_DIV, 32'hABCD_0004);
    check_reg("div_4", A_DIV, 32'd4);
    wr(A_CTRL, 32'd1);
    exp_q.push_back(make_frame(8'hA5, 4, 1'b0));
    wr(A_DATA, 32'h1234_56A5);
    check_reg("single_status_queued", A_STATUS, status_word(0, 1, 0));
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      rd(A_STATUS, v);
      if (v[0]) begin
        busy_cycles++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("single_busy_cycles", 32'(busy_cycles), 32'd40);
    drain("single");

    // FIFO fill and overflow with the transmitter disabled, then a back-to-back drain.
    wr(A_CTRL, 32'd0);
    cnt = 0;
    ovf = 0;
    for (int i = 1; i <= 5; i++) begin
      if (cnt < DEPTH) begin
        exp_q.push_back(make_frame(8'(i), 4, cnt > 0));
        cnt++;
      end else begin
        ovf = 1;
      end
      wr(A_DATA, 32'(i));
    end
    check_reg("fifo_full_ovf", A_STATUS, status_word(0, cnt, ovf));
    wr(A_STATUS, $urandom);
    check_reg("fifo_ovf_cleared", A_STATUS, status_word(0, cnt, 0));
    wr(A_CTRL, 32'd1);
    drain("fifo");
    check_reg("fifo_empty_after", A_STATUS, 32'h4);

    // IRQ: the level rises once the line goes idle with an empty FIFO and drops on a DATA write.
    wr(A_DIV, 32'd1);
    wr(A_CTRL, 32'hFFFF_FFFF);
    check_reg("ctrl_reads_3", A_CTRL, 32'd3);
    check("irq_idle_empty", 32'(IRQ), 32'd1);
    exp_q.push_back(make_frame(8'h00, 1, 1'b0));
    wr(A_DATA, 32'h0);
    #1;
    check("irq_drop_on_write", 32'(IRQ), 32'd0);
    delay = 0;
    for (int i = 1; i < 100; i++) begin
      step();
      #1;
      if (IRQ === 1'b1) begin
        delay = i;
        break;
      end
    end
    check("irq_rise_delay", 32'(delay), 32'd11);
    exp_q.push_back(make_frame(8'h3C, 1, 1'b0));
    wr(A_DATA, 32'h3C);
    #1;
    check("irq_drop_on_write2", 32'(IRQ), 32'd0);
    wr(A_CTRL, 32'd1);
    drain("irq");
    #1;
    check("irq_masked", 32'(IRQ), 32'd0);

    // Mid-frame DIV change during data bit 3, queue a byte, then clear tx_en during bit 4.
    wr(A_DIV, 32'd2);
    f = make_frame(8'hFF, 2, 1'b0);
    for (int k = 5; k < 10; k++) f.dur[k] = 5;
    exp_q.push_back(f);
    wr(A_DATA, 32'hFF);
    idle(9);
    wr(A_DIV, 32'd5);
    check_reg("mid_div_5", A_DIV, 32'd5);
    wr(A_DATA, 32'h5A);
    wr(A_CTRL, 32'd0);
    check_reg("mid_ctrl_cleared", A_CTRL, 32'd0);
    check_reg("mid_still_busy", A_STATUS, status_word(1, 1, 0));
    for (int i = 0; i < 200; i++) begin
      rd(A_STATUS, v);
      if (!v[0]) break;
      step();
    end
    check_reg("mid_fifo_retained", A_STATUS, status_word(0, 1, 0));
    check("mid_frame_seen", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(make_frame(8'h5A, 5, 1'b0));
    wr(A_CTRL, 32'd1);
    drain("mid");

    // Reset mid-frame. The second byte is pushed on the same edge as the first is popped.
    wr(A_DIV, 32'd3);
    f = make_frame(8'h96, 3, 1'b0);
    f.abort = 1'b1;
    exp_q.push_back(f);
    wr(A_DATA, 32'h96);
    wr(A_DATA, 32'h69);
    check_reg("push_pop_same_cycle", A_STATUS, status_word(1, 1, 0));
    idle(10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rstmid_txd", 32'(txd), 32'd1);
    check_reg("rstmid_status", A_STATUS, 32'h4);
    check_reg("rstmid_ctrl", A_CTRL, 32'd0);
    check_reg("rstmid_div", A_DIV, 32'd16);
    idle(5);
    check("rstmid_txd_idle", 32'(txd), 32'd1);
    check("rstmid_frame_consumed", 32'(exp_q.size()), 32'd0);

    // Randomised batches: random divisor and byte count, filled while disabled, then drained.
    for (int it = 0; it < 6; it++) begin
      wr(A_CTRL, 32'd0);
      dw  = $urandom_range(0, 6);
      div = (dw == 0) ? 1 : dw;
      wr(A_DIV, 32'(dw));
      check_reg($sformatf("rnd%0d_div", it), A_DIV, 32'(div));
      n   = $urandom_range(1, 6);
      cnt = 0;
      ovf = 0;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (cnt < DEPTH) begin
          exp_q.push_back(make_frame(b, div, cnt > 0));
          cnt++;
        end else begin
          ovf = 1;
        end
        wr(A_DATA, {24'($urandom), b});
      end
      check_reg($sformatf("rnd%0d_status", it), A_STATUS, status_word(0, cnt, ovf));
      if (ovf != 0) begin
        wr(A_STATUS, 32'd0);
        check_reg($sformatf("rnd%0d_ovf_clr", it), A_STATUS, status_word(0, cnt, 0));
      end
      irq_bit = $urandom_range(0, 1);
      wr(A_CTRL, 32'(1 + 2 * irq_bit));
      drain($sformatf("rnd%0d", it));
      #1;
      check($sformatf("rnd%0d_irq", it), 32'(IRQ), 32'(irq_bit));
      check_reg($sformatf("rnd%0d_idle_status", it), A_STATUS, 32'h4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
